pwm_led_driver: RTL
===================

// Module: pwm_led_driver
// PURPOSE
//   Register-programmed PWM generator driving the board's external PID-controlled LED (pid_LED, PMOD JB1).
//   Sits between the embedded system's register interface and the LED pin.
//   The processor writes period/duty/control; shadow registers apply changes only at period boundaries
//   so the light sensor never sees glitched cycles.
// PARAMETERS
//   CNT_W           16      width of period counter, period and duty registers
//   DEFAULT_PERIOD  16'd4095  reset value of pending/active period (PWM period = P+1 clocks)
//   RAMP_STEP       16'd16  max duty change per period when PWM_RAMP_EN is defined
// PORTS
//   clk         in   1      system clock (100 MHz)
//   reset       in   1      asynchronous, active-high reset
//   wr_en       in   1      register write strobe, one cycle
//   wr_addr     in   2      0=period, 1=duty, 2=control{[1]=invert,[0]=enable}, 3=reserved (write ignored)
//   wr_data     in   CNT_W  write data
//   rd_addr     in   2      read select, same map
//   rd_data     out  CNT_W  combinational read of PENDING regs; addr 3 reads active duty
//   pwm_out     out  1      registered PWM output to LED pin
//   period_tick out  1      one-cycle pulse on last cycle of every period (registered, aligned with pwm_out)
// BEHAVIOUR
//   Reset: pending period=DEFAULT_PERIOD, pending duty=0, control=0; active period=DEFAULT_PERIOD,
//     active duty=0; cnt=0; pwm_out=0; period_tick=0.
//   Write: pending reg updated at the clock edge where wr_en=1; no effect on active regs until transfer.
//   Counter (enable=1): cnt counts 0..act_period, wraps to 0; boundary = cycle with cnt==act_period.
//   Transfer: at boundary edge, act_period<=pend_period, act_duty<=pend_duty (pre-edge values).
//     Write in the same cycle as boundary -> missed; applied at the following boundary.
//   Output: raw = (cnt < act_duty); pwm_out <= raw ^ invert; one clock latency from cnt.
//     act_duty=0 -> constant 0% (inactive level); act_duty > act_period -> constant 100%.
//   period_tick <= (cnt==act_period) & enable; same latency as pwm_out.
//   enable=0: cnt held at 0, pwm_out <= invert (idle inactive level), period_tick=0,
//     active regs load from pending every cycle (immediate update while disabled).
//   Enable 0->1: first period starts with cnt=0 in the cycle after the control write lands.
//   Invert changes take effect one cycle after the control write (not shadowed).
//   act_period=0: period of 1 clock; pwm_out constant (duty>=1 -> 100%, else 0%), tick every cycle.
//   Reset asserted mid-period: all state returns to reset values immediately (async), output low.
// CONFIGURATION
//   PWM_RAMP_EN defined: at each boundary act_duty moves toward pend_duty by at most RAMP_STEP
//     (saturating; exact hit when |diff|<=RAMP_STEP); act_period still transfers directly.
//     While disabled, act_duty still loads directly (no ramp).
//   PWM_RAMP_EN undefined: act_duty <= pend_duty directly at boundary; RAMP_STEP unused.
// TESTING
//   Reset, no writes -> pwm_out=0, period_tick=0, rd_data(addr0)=4095 for 10000 cycles.
//   period=9, duty=3, enable=1 -> pwm_out high 3 of every 10 clocks; tick every 10th clock.
//   Running period=9,duty=3; write duty=7 mid-period -> current period still 3 high; next period 7 high.
//   Write duty=5 exactly on boundary cycle -> next period still old duty; the one after shows 5.
//   duty=0 -> pwm_out constant 0; duty=12 with period=9 -> constant 1; invert=1 flips both.
//   PWM_RAMP_EN, RAMP_STEP=16, period=255, duty 0->100 -> active duty 16,32,..,96,100 over 7 periods.

Source files
------------

// File: rtl/pwm_led_driver.sv
// rtl/pwm_led_driver.sv - shadow-registered PWM generator for the PID-controlled LED pin
// Optional duty ramping at period boundaries is built when PWM_RAMP_EN is defined.
module pwm_led_driver #(
  parameter int                CNT_W          = 16,
  parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = 16'd4095
`ifdef PWM_RAMP_EN
  ,
  parameter logic [CNT_W-1:0]  RAMP_STEP      = 16'd16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             pwm_out,
  output logic             period_tick
);

  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_duty;
  logic [1:0]       ctrl;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_next;
  logic             enable;
  logic             invert;
  logic             boundary;

  assign enable   = ctrl[0];
  assign invert   = ctrl[1];
  assign boundary = (cnt == act_period);

  // Duty value adopted at the next period boundary
  always_comb begin
    duty_next = pend_duty;
`ifdef PWM_RAMP_EN
    if (pend_duty > act_duty) begin
      if ((pend_duty - act_duty) > RAMP_STEP)
        duty_next = act_duty + RAMP_STEP;
    end else begin
      if ((act_duty - pend_duty) > RAMP_STEP)
        duty_next = act_duty - RAMP_STEP;
    end
`endif
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = pend_period;
      2'd1:    rd_data = pend_duty;
      2'd2:    rd_data = {{(CNT_W-2){1'b0}}, ctrl};
      default: rd_data = act_duty;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_period <= DEFAULT_PERIOD;
      pend_duty   <= '0;
      ctrl        <= 2'b00;
      act_period  <= DEFAULT_PERIOD;
      act_duty    <= '0;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          2'd0:    pend_period <= wr_data;
          2'd1:    pend_duty   <= wr_data;
          2'd2:    ctrl        <= wr_data[1:0];
          default: ;
        endcase
      end

      if (!enable) begin
        // Idle: hold the counter and let the active set track pending directly
        cnt         <= '0;
        act_period  <= pend_period;
        act_duty    <= pend_duty;
        pwm_out     <= invert;
        period_tick <= 1'b0;
      end else begin
        pwm_out     <= (cnt < act_duty) ^ invert;
        period_tick <= boundary;
        if (boundary) begin
          cnt        <= '0;
          act_period <= pend_period;
          act_duty   <= duty_next;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
